filter_capture_sequencer: RTL

//  Parametrised capture/replay front end and score classifier for the matched-filter bank.
//  - On a trigger, captures CAPTURE_LENGTH samples from the ADC stream into internal block RAM.
//  - Replays the captured buffer REPLAY_COUNT times, with a fixed idle gap between passes.
//  - Picks the lowest of NUM_FILTERS packed filter scores and reports the winning class index.
//  - Sits between the sample source and the matched_filter instances; drives the LED/SPI debug logic.

---
 rtl/filter_capture_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/filter_capture_sequencer.sv
// filter_capture_sequencer: captures a block of ADC samples on trigger, replays it a fixed
// number of passes with an idle gap after each pass, and classifies packed filter scores
// by unsigned minimum (lowest index wins ties).
// Optional feature macro: FSEQ_MARGIN_EN adds class_margin (second-lowest minus lowest score).
module filter_capture_sequencer #(
    parameter int unsigned SAMPLE_W       = 8,
    parameter int unsigned SCORE_W        = 32,
    parameter int unsigned CAPTURE_LENGTH = 1000,
    parameter int unsigned NUM_FILTERS    = 4,
    parameter int unsigned REPLAY_COUNT   = 2001,
    parameter int unsigned GAP_CYCLES     = 2,
    localparam int unsigned CLASS_W       = $clog2(NUM_FILTERS),
    localparam int unsigned PASS_W        = $clog2(REPLAY_COUNT + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           trigger,
    input  logic                           s_valid,
    input  logic [SAMPLE_W-1:0]            s_data,
    output logic                           replay_valid,
    output logic [SAMPLE_W-1:0]            replay_data,
    output logic                           replay_last,
    input  logic                           scores_valid,
    input  logic [NUM_FILTERS*SCORE_W-1:0] scores,
    output logic                           class_valid,
    output logic [CLASS_W-1:0]             class_idx,
    output logic                           class_tie,
`ifdef FSEQ_MARGIN_EN
    output logic [SCORE_W-1:0]             class_margin,
`endif
    output logic                           busy,
    output logic [PASS_W-1:0]              pass_count
);

    localparam int unsigned AW = $clog2(CAPTURE_LENGTH);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StCapture, StReplay, StGap} state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [GW-1:0]       gap_cnt_q;
    logic [PASS_W-1:0]   pass_q;
    logic [SAMPLE_W-1:0] mem [CAPTURE_LENGTH];

    logic                replay_valid_q, replay_last_q;
    logic [SAMPLE_W-1:0] replay_data_q;

    logic wr_last, rd_last, gap_done, last_pass;

    assign wr_last   = (wr_ptr_q == AW'(CAPTURE_LENGTH - 1));
    assign rd_last   = (rd_ptr_q == AW'(CAPTURE_LENGTH - 1));
    assign gap_done  = (gap_cnt_q == GW'(GAP_CYCLES - 1));
    assign last_pass = (pass_q == PASS_W'(REPLAY_COUNT - 1));

    // State register; synchronous reset aborts any operation immediately.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (trigger) state_d = StCapture;
            StCapture: if (s_valid && wr_last) state_d = StReplay;
            StReplay:  if (rd_last) state_d = StGap;
            StGap:     if (gap_done) state_d = last_pass ? StIdle : StReplay;
            default:   state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q != StIdle);
    end

    // Write/read pointers, gap counter and pass counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            gap_cnt_q <= '0;
            pass_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end
                StCapture: begin
                    if (s_valid) wr_ptr_q <= wr_last ? '0 : wr_ptr_q + AW'(1);
                end
                StReplay: begin
                    rd_ptr_q  <= rd_last ? '0 : rd_ptr_q + AW'(1);
                    gap_cnt_q <= '0;
                end
                StGap: begin
                    if (gap_done) begin
                        gap_cnt_q <= '0;
                        pass_q    <= last_pass ? '0 : pass_q + PASS_W'(1);
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Capture buffer write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && state_q == StCapture && s_valid) mem[wr_ptr_q] <= s_data;
    end

    // Registered read port: data for address k appears the cycle after k is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            replay_valid_q <= 1'b0;
            replay_last_q  <= 1'b0;
            replay_data_q  <= '0;
        end else begin
            replay_valid_q <= (state_q == StReplay);
            replay_last_q  <= (state_q == StReplay) && rd_last;
            if (state_q == StReplay) replay_data_q <= mem[rd_ptr_q];
        end
    end

    assign replay_valid = replay_valid_q;
    assign replay_data  = replay_data_q;
    assign replay_last  = replay_last_q;
    assign pass_count   = pass_q;

    // Classifier: unsigned argmin, strict compare keeps the lowest index on ties.
    logic [SCORE_W-1:0] min_val;
    logic [CLASS_W-1:0] min_idx;
    logic               min_tie;

    // Find minimum and whether any other index shares it.
    always_comb begin
        min_val = scores[0 +: SCORE_W];
        min_idx = '0;
        min_tie = 1'b0;
        for (int i = 1; i < int'(NUM_FILTERS); i++) begin
            if (scores[i*SCORE_W +: SCORE_W] < min_val) begin
                min_val = scores[i*SCORE_W +: SCORE_W];
                min_idx = CLASS_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_FILTERS); i++) begin
            if (scores[i*SCORE_W +: SCORE_W] == min_val && CLASS_W'(i) != min_idx) min_tie = 1'b1;
        end
    end

    logic               class_valid_q, class_tie_q;
    logic [CLASS_W-1:0] class_idx_q;

`ifdef FSEQ_MARGIN_EN
    logic [SCORE_W-1:0] second_val, class_margin_q;

    // Second-lowest score over all indices except the winner; equals min on a tie.
    always_comb begin
        second_val = '1;
        for (int i = 0; i < int'(NUM_FILTERS); i++) begin
            if (CLASS_W'(i) != min_idx && scores[i*SCORE_W +: SCORE_W] < second_val) begin
                second_val = scores[i*SCORE_W +: SCORE_W];
            end
        end
    end

    // Margin register, updated alongside the class result.
    always_ff @(posedge clk) begin
        if (rst)               class_margin_q <= '0;
        else if (scores_valid) class_margin_q <= second_val - min_val;
    end

    assign class_margin = class_margin_q;
`else
    // Margin path not built: classifier reports index and tie only.
`endif

    // Class result register; idx/tie hold until the next scores_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            class_valid_q <= 1'b0;
            class_idx_q   <= '0;
            class_tie_q   <= 1'b0;
        end else begin
            class_valid_q <= scores_valid;
            if (scores_valid) begin
                class_idx_q <= min_idx;
                class_tie_q <= min_tie;
            end
        end
    end

    assign class_valid = class_valid_q;
    assign class_idx   = class_idx_q;
    assign class_tie   = class_tie_q;

endmodule
